// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master) and memory (slave).
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: one request in flight, registered output buffer to ID; a word lands one edge after ack.
// ID stalls block new requests only; `IF_PREFETCH_EN adds a one-entry prefetch filled while ID is stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_wpcir,
  input  logic        jmp_stall,
  input  logic        cu_branch,
  input  logic [31:0] nid_pc,
  if_stage_if.master  imem,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic [3:0]  IF_ins_type,
  output logic [3:0]  IF_ins_number
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] addr_q;
  logic        req_q;
  logic        ivalid;
  logic        advance;
`ifdef IF_PREFETCH_EN
  logic [31:0] pf_word;
  logic        pf_vld;
`endif

  assign advance        = !id_wpcir && !jmp_stall;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  function automatic logic [3:0] ins_type(input logic [31:0] w);
    case (w[31:26])
      6'b000000:            ins_type = 4'd1;
      6'b100011:            ins_type = 4'd3;
      6'b101011:            ins_type = 4'd4;
      6'b000100, 6'b000101: ins_type = 4'd5;
      6'b000010, 6'b000011: ins_type = 4'd6;
      default:              ins_type = 4'd2;
    endcase
  endfunction

  // A request is only issued while the output buffer is empty (or draining),
  // so a returning word always has somewhere to land.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      ivalid        <= 1'b0;
      if_inst       <= 32'h0;
      if_pc4        <= 32'h0;
      IF_ins_type   <= 4'h0;
      IF_ins_number <= 4'h0;
      req_q         <= 1'b0;
      addr_q        <= RESET_PC;
`ifdef IF_PREFETCH_EN
      pf_word       <= 32'h0;
      pf_vld        <= 1'b0;
`endif
    end else if (cu_branch) begin
      pc          <= nid_pc;
      ivalid      <= 1'b0;
      if_inst     <= 32'h0;
      IF_ins_type <= 4'h0;
`ifdef IF_PREFETCH_EN
      pf_vld      <= 1'b0;
`endif
      // An unanswered request must complete on the bus; its data is dropped in DISCARD.
      if (req_q && !imem.imem_ack) begin
        state <= DISCARD;
      end else begin
        state  <= FETCH;
        req_q  <= 1'b1;
        addr_q <= nid_pc;
      end
    end else begin
      case (state)
        IDLE: begin
          state  <= FETCH;
          req_q  <= 1'b1;
          addr_q <= pc;
        end
        FETCH: begin
          if (req_q) begin
            if (imem.imem_ack) begin
              ivalid        <= 1'b1;
              if_inst       <= imem.imem_rdata;
              if_pc4        <= pc + 32'd4;
              IF_ins_type   <= ins_type(imem.imem_rdata);
              IF_ins_number <= IF_ins_number + 4'd1;
              pc            <= pc + 32'd4;
              req_q         <= 1'b0;
            end
          end else if (ivalid && !advance) begin
            state <= HOLD;
`ifdef IF_PREFETCH_EN
            req_q  <= 1'b1;
            addr_q <= pc;
`endif
          end else begin
            ivalid      <= 1'b0;
            if_inst     <= 32'h0;
            IF_ins_type <= 4'h0;
            req_q       <= 1'b1;
            addr_q      <= pc;
          end
        end
        HOLD: begin
`ifdef IF_PREFETCH_EN
          if (req_q && imem.imem_ack) begin
            pc    <= pc + 32'd4;
            req_q <= 1'b0;
            if (advance) begin
              state         <= FETCH;
              if_inst       <= imem.imem_rdata;
              if_pc4        <= pc + 32'd4;
              IF_ins_type   <= ins_type(imem.imem_rdata);
              IF_ins_number <= IF_ins_number + 4'd1;
            end else begin
              pf_word <= imem.imem_rdata;
              pf_vld  <= 1'b1;
            end
          end else if (advance) begin
            state <= FETCH;
            if (pf_vld) begin
              // pc already points past the prefetched word
              if_inst       <= pf_word;
              if_pc4        <= pc;
              IF_ins_type   <= ins_type(pf_word);
              IF_ins_number <= IF_ins_number + 4'd1;
              pf_vld        <= 1'b0;
            end else begin
              ivalid      <= 1'b0;
              if_inst     <= 32'h0;
              IF_ins_type <= 4'h0;
              if (!req_q) begin
                req_q  <= 1'b1;
                addr_q <= pc;
              end
            end
          end
`else
          if (advance) begin
            state       <= FETCH;
            ivalid      <= 1'b0;
            if_inst     <= 32'h0;
            IF_ins_type <= 4'h0;
            req_q       <= 1'b1;
            addr_q      <= pc;
          end
`endif
        end
        DISCARD: begin
          if (imem.imem_ack) begin
            state  <= FETCH;
            req_q  <= 1'b1;
            addr_q <= pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random stalls/redirects/acks, checked
// against a transaction-level queue model of fetched words.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_wpcir, jmp_stall, cu_branch;
  logic [31:0] nid_pc;
  logic [31:0] if_inst, if_pc4;
  logic [3:0]  IF_ins_type, IF_ins_number;

  if_stage_if imem();

  if_stage dut (
    .clk(clk), .rst(rst), .id_wpcir(id_wpcir), .jmp_stall(jmp_stall),
    .cu_branch(cu_branch), .nid_pc(nid_pc), .imem(imem),
    .if_inst(if_inst), .if_pc4(if_pc4), .IF_ins_type(IF_ins_type), .IF_ins_number(IF_ins_number)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc4;
    logic        shown;
    logic [3:0]  tag;
  } item_t;

  item_t       q[$];
  logic [31:0] exp_pc = 32'h0;
  logic [3:0]  exp_tag = 4'h0;
  logic        stale = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          consumed = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] op;
    case (a[4:2])
      3'd0: op = 6'b000000;
      3'd1: op = 6'b100011;
      3'd2: op = 6'b101011;
      3'd3: op = 6'b000100;
      3'd4: op = 6'b000101;
      3'd5: op = 6'b000010;
      3'd6: op = 6'b000011;
      default: op = 6'b001000;
    endcase
    return {op, a[27:2] ^ 26'h155_5555};
  endfunction

  function automatic logic [3:0] cls(input logic [31:0] w);
    logic [5:0] o;
    o = w[31:26];
    if (o == 6'b000000) return 4'd1;
    if (o == 6'b100011) return 4'd3;
    if (o == 6'b101011) return 4'd4;
    if (o == 6'b000100 || o == 6'b000101) return 4'd5;
    if (o == 6'b000010 || o == 6'b000011) return 4'd6;
    return 4'd2;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  task automatic check_outputs();
    item_t it;
    if (if_inst !== 32'h0) begin
      if (q.size() == 0) chk("spurious_inst", if_inst, 32'h0);
      else begin
        it = q[0];
        if (!it.shown) begin
          exp_tag  = exp_tag + 4'd1;
          it.shown = 1'b1;
          it.tag   = exp_tag;
          q[0]     = it;
        end
        chk("if_inst", if_inst, it.word);
        chk("if_pc4", if_pc4, it.pc4);
        chk("ins_type", 32'(IF_ins_type), 32'(cls(it.word)));
        chk("ins_number", 32'(IF_ins_number), 32'(it.tag));
      end
    end else begin
      chk("type_when_empty", 32'(IF_ins_type), 32'h0);
      if (q.size() > 0 && q[0].shown) chk("inst_lost", if_inst, q[0].word);
    end
  endtask

  // One clock: drive at negedge, check, update the model at posedge, check request hold.
  task automatic step(input logic r, input logic st, input logic js, input logic br,
                      input logic [31:0] np, input logic ak);
    logic        pre_req;
    logic [31:0] pre_addr, pre_inst;
    item_t       it;
    rst = r; id_wpcir = st; jmp_stall = js; cu_branch = br; nid_pc = np;
    imem.imem_ack   = ak;
    imem.imem_rdata = ak ? mem_word(imem.imem_addr) : 32'hDEAD_BEEF;
    pre_req  = imem.imem_req;
    pre_addr = imem.imem_addr;
    pre_inst = if_inst;
    if (r) check_outputs();
    @(posedge clk);
    if (!r) begin
      q.delete(); exp_pc = 32'h0; exp_tag = 4'h0; stale = 1'b0;
    end else begin
      if (!st && !js && pre_inst !== 32'h0 && q.size() > 0 && q[0].shown) begin
        void'(q.pop_front());
        consumed++;
      end
      if (br) begin
        q.delete();
        stale  = pre_req && !ak;
        exp_pc = np;
      end else if (pre_req && ak) begin
        if (stale) stale = 1'b0;
        else begin
          chk("fetch_addr", pre_addr, exp_pc);
          it.word = mem_word(pre_addr); it.pc4 = pre_addr + 32'd4; it.shown = 1'b0; it.tag = 4'h0;
          q.push_back(it);
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    @(negedge clk);
    if (r && pre_req && !ak) begin
      chk("req_held", 32'(imem.imem_req), 32'h1);
      chk("addr_held", imem.imem_addr, pre_addr);
    end
  endtask

  initial begin
    int          n, reqs;
    logic [3:0]  tag_b, t, prev_num;
    logic        seen_pc, seen_tag, st, js, br, ak;
    logic [31:0] last_addr, np;
    rst = 1'b0; id_wpcir = 1'b0; jmp_stall = 1'b0; cu_branch = 1'b0; nid_pc = 32'h0;
    imem.imem_ack = 1'b0; imem.imem_rdata = 32'h0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_req", 32'(imem.imem_req), 32'h0);
    chk("rst_addr", imem.imem_addr, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
    chk("rst_type", 32'(IF_ins_type), 32'h0);
    chk("rst_num", 32'(IF_ins_number), 32'h0);

    // Release with ack held high: the IDLE-cycle ack is ignored, then 0,4,8 are fetched.
    step(1, 0, 0, 0, 0, 1);
    chk("first_req", 32'(imem.imem_req), 32'h1);
    chk("first_addr", imem.imem_addr, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 1);
      if (i % 2 == 0) begin
        chk("seq_inst", if_inst, mem_word(32'(i * 2)));
        chk("seq_num", 32'(IF_ins_number), 32'(i / 2 + 1));
      end
    end
    chk("ibuf_pc4_12", if_pc4, 32'd12);

    // Three-cycle ID stall with the word at 8 buffered.
    reqs = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 1);
      chk("stall_inst", if_inst, mem_word(32'h8));
      chk("stall_pc4", if_pc4, 32'd12);
      if (imem.imem_req) begin
        reqs++;
        chk("hold_fetch_addr", imem.imem_addr, 32'd12);
      end
    end
`ifdef IF_PREFETCH_EN
    chk("hold_reqs", 32'(reqs), 32'h1);
`else
    chk("hold_reqs", 32'(reqs), 32'h0);
`endif

    // Redirect to 0x40 while 0x10 is outstanding; the late ack is dropped.
    n = 0;
    while (!(imem.imem_req === 1'b1 && imem.imem_addr === 32'h10) && n < 20) begin
      step(1, 0, 0, 0, 0, 1);
      n++;
    end
    chk("reach_req_10", 32'(n < 20), 32'h1);
    tag_b = IF_ins_number;
    step(1, 0, 0, 1, 32'h40, 0);
    chk("disc_req", 32'(imem.imem_req), 32'h1);
    chk("disc_addr", imem.imem_addr, 32'h10);
    chk("disc_inst", if_inst, 32'h0);
    chk("disc_type", 32'(IF_ins_type), 32'h0);
    step(1, 0, 0, 0, 0, 0);
    chk("disc_inst2", if_inst, 32'h0);
    step(1, 0, 0, 0, 0, 1);
    chk("redir_req", 32'(imem.imem_req), 32'h1);
    chk("redir_addr", imem.imem_addr, 32'h40);
    chk("redir_inst", if_inst, 32'h0);
    chk("redir_num", 32'(IF_ins_number), 32'(tag_b));

    // Redirect coincident with ack while ID stalls: data dropped, tag unchanged.
    step(1, 1, 0, 1, 32'h40, 1);
    chk("coinc_addr", imem.imem_addr, 32'h40);
    chk("coinc_inst", if_inst, 32'h0);
    chk("coinc_num", 32'(IF_ins_number), 32'(tag_b));
    step(1, 0, 0, 0, 0, 1);
    t = tag_b + 4'd1;
    chk("after_coinc_inst", if_inst, mem_word(32'h40));
    chk("after_coinc_num", 32'(IF_ins_number), 32'(t));

    // pc wrap from 0xFFFF_FFF8 and tag wrap.
    step(1, 0, 0, 1, 32'hFFFF_FFF8, 0);
    seen_pc = 1'b0; seen_tag = 1'b0; last_addr = 32'h1; prev_num = IF_ins_number;
    for (int i = 0; i < 60; i++) begin
      if (imem.imem_req && imem.imem_addr != last_addr) begin
        if (last_addr == 32'hFFFF_FFFC && imem.imem_addr == 32'h0) seen_pc = 1'b1;
        last_addr = imem.imem_addr;
      end
      if (prev_num == 4'hF && IF_ins_number == 4'h0) seen_tag = 1'b1;
      prev_num = IF_ins_number;
      step(1, 0, 0, 0, 0, 1);
    end
    chk("pc_wrap", 32'(seen_pc), 32'h1);
    chk("tag_wrap", 32'(seen_tag), 32'h1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 3) == 0);
      js = ($urandom_range(0, 7) == 0);
      br = ($urandom_range(0, 15) == 0);
      np = $urandom();
      np[1:0] = 2'b00;
      ak = ($urandom_range(0, 9) < 6);
      step(1, st, js, br, np, ak);
    end

    // Reset while a request is outstanding; ack right after release is ignored.
    n = 0;
    while (imem.imem_req !== 1'b1 && n < 20) begin
      step(1, 0, 0, 0, 0, 0);
      n++;
    end
    chk("req_before_reset", 32'(imem.imem_req), 32'h1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst2_req", 32'(imem.imem_req), 32'h0);
    chk("rst2_num", 32'(IF_ins_number), 32'h0);
    step(1, 0, 0, 0, 0, 1);
    chk("rst2_release_addr", imem.imem_addr, 32'h0);
    chk("rst2_release_inst", if_inst, 32'h0);
    step(1, 0, 0, 0, 0, 1);
    chk("rst2_first_inst", if_inst, mem_word(32'h0));
    chk("rst2_first_num", 32'(IF_ins_number), 32'h1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 1);

    chk("progress", 32'(consumed >= 60), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
